addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder-subtractor; the successor to the fixed 8-bit combinational adder-subtractor.
- Operand width is split into LANE-bit slices, one slice per pipeline stage, with the carry registered between stages. Each operation carries its own Mode.
- Valid/ready handshake on both sides, full backpressure, and a per-result flag set (Carry, Overflow, Zero, Negative).
- Sits between operand registers and result registers in the datapath. Sustains one operation per clock.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of LANE and at least 2.
- LANE, 4, bits resolved per pipeline stage. STAGES = WIDTH/LANE is derived, not a parameter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  A, B and Mode are valid this cycle.
- in_ready  output  1  block accepts the operation this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Mode  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  S and the flags hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- S  output  WIDTH  result.
- Carry  output  1  carry out of bit WIDTH-1. In subtract mode, 1 = no borrow.
- Overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Zero  output  1  S == 0 (evaluated after the optional saturation).
- Negative  output  1  S[WIDTH-1].

Behaviour:
- Reset:
  - While Rst_n is low at a rising edge, all stage valid bits, S, Carry, Overflow, Zero and Negative clear to 0.
  - out_valid = 0 and in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards every in-flight operation; no partial result ever appears.
- Arithmetic:
  - B_M = B XOR {WIDTH{Mode}}; carry-in to slice 0 = Mode.
  - Result equals (A + B_M + Mode) mod 2^WIDTH.
- Pipeline:
  - Stage k (k = 0..STAGES-1) adds slice k of A and B_M plus the carry registered from stage k-1.
  - Upper operand slices and Mode travel with the operation. Already-computed lower result slices are delayed so all slices align at the output.
  - Carry and Overflow come from the final stage's carry-in/carry-out of bit WIDTH-1.
  - Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. STAGES cycles.
- Advance and stall:
  - Global advance = !out_valid | out_ready. in_ready = advance (combinational).
  - On advance, every stage shifts by one. A bubble (valid = 0) enters when in_valid is low.
  - On stall (out_valid & !out_ready), every stage register holds, including S and flags.
  - A is transferred when in_valid & in_ready. A result is consumed when out_valid & out_ready.
  - Simultaneous accept and consume in one cycle is legal and loses nothing.
  - Results leave in acceptance order. No operation is ever dropped or duplicated.
- Holding rules:
  - Inputs may change freely when not accepted.
  - Outputs are stable while out_valid & !out_ready.
- Timing: no combinational path from A/B/Mode to any output. The only combinational input-to-output path is out_ready -> in_ready.
- Elaboration: WIDTH % LANE != 0 fails at elaboration.

Optional Feature:
- Macro ADDSUB_PIPE_SATURATE_EN.
- Defined:
  - When Overflow = 1, S is clamped: positive overflow (A sign = 0 in the effective addition) -> 0 followed by WIDTH-1 ones; negative overflow -> 1 followed by WIDTH-1 zeros.
  - Overflow and Carry still report the unclamped operation.
  - Zero and Negative reflect the clamped S. Latency is unchanged.
- Not defined: S wraps modulo 2^WIDTH. No saturation logic is present.

Test Plan:
- Reset (WIDTH=16, LANE=4): hold Rst_n = 0 for 2 edges with in_valid = 1 -> out_valid = 0, S = 0x0000, all flags 0, in_ready = 1 after release.
- Add: A = 0x0001, B = 0x0001, Mode = 0 -> 4 cycles later S = 0x0002, Carry = 0, Overflow = 0, Zero = 0. Then A = 0xFFFF, B = 0xBABA -> S = 0xBAB9, Carry = 1, Overflow = 0, Negative = 1.
- Overflow add: A = 0x8000, B = 0x8000, Mode = 0 -> S = 0x0000, Carry = 1, Overflow = 1, Zero = 1 (with saturation: S = 0x8000, Zero = 0).
- Subtract: A = 0x4200, B = 0x8800, Mode = 1 -> S = 0xBA00, Carry = 0, Overflow = 1 (with saturation: S = 0x7FFF, Negative = 0). Then A = 0x6100, B = 0x0900 -> S = 0x5800, Carry = 1, Overflow = 0.
- Backpressure: stream 8 back-to-back operations (mixed Mode), hold out_ready = 0 for 3 cycles mid-stream -> in_ready = 0 during the stall, outputs frozen, all 8 results delivered in order with correct values.
- Reset mid-stream: assert Rst_n = 0 with 3 operations in flight -> none of them ever appears on the output. A fresh operation after release returns its result 4 cycles after acceptance.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder-subtractor, LANE bits resolved per stage with the carry registered between stages.
// Optional clamping of overflowed results is enabled by defining ADDSUB_PIPE_SATURATE_EN.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int STAGES = WIDTH / LANE;
    localparam int PSTG   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L      = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    generate
        if ((WIDTH % LANE) != 0 || WIDTH < 2) begin : g_param_check
            $error("addsub_pipe: WIDTH must be a multiple of LANE and at least 2");
        end
    endgenerate

    // Registers between stages; the final stage writes the output registers instead.
    logic [WIDTH-1:0] r_a [PSTG];
    logic [WIDTH-1:0] r_b [PSTG];
    logic [WIDTH-1:0] r_s [PSTG];
    logic             r_c [PSTG];
    logic             r_v [PSTG];

    logic [WIDTH-1:0] in_a  [STAGES];
    logic [WIDTH-1:0] in_b  [STAGES];
    logic [WIDTH-1:0] in_s  [STAGES];
    logic             in_c  [STAGES];
    logic             in_v  [STAGES];
    logic [LANE:0]    lane_sum [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];

    logic             advance;
    logic             carry_msb;
    logic             ovf;
    logic [WIDTH-1:0] res;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    always_comb begin
        in_a[0] = A;
        in_b[0] = B ^ {WIDTH{Mode}};
        in_s[0] = '0;
        in_c[0] = Mode;
        in_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            in_a[k] = r_a[k-1];
            in_b[k] = r_b[k-1];
            in_s[k] = r_s[k-1];
            in_c[k] = r_c[k-1];
            in_v[k] = r_v[k-1];
        end
        // Each stage fills in its own slice and leaves the others untouched.
        for (int k = 0; k < STAGES; k++) begin
            lane_sum[k] = {1'b0, in_a[k][k*LANE +: LANE]}
                        + {1'b0, in_b[k][k*LANE +: LANE]}
                        + {{LANE{1'b0}}, in_c[k]};
            nxt_s[k] = in_s[k];
            nxt_s[k][k*LANE +: LANE] = lane_sum[k][LANE-1:0];
            nxt_c[k] = lane_sum[k][LANE];
        end
        carry_msb = in_a[L][MSB] ^ in_b[L][MSB] ^ nxt_s[L][MSB];
        ovf       = carry_msb ^ nxt_c[L];
`ifdef ADDSUB_PIPE_SATURATE_EN
        if (ovf) begin
            res = in_a[L][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end else begin
            res = nxt_s[L];
        end
`else
        res = nxt_s[L];
`endif
    end

    // The whole pipeline moves together; a stall freezes every register.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_v[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            S         <= '0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_v[k] <= in_v[k];
                r_a[k] <= in_a[k];
                r_b[k] <= in_b[k];
                r_s[k] <= nxt_s[k];
                r_c[k] <= nxt_c[k];
            end
            out_valid <= in_v[L];
            S         <= res;
            Carry     <= nxt_c[L];
            Overflow  <= ovf;
            Zero      <= (res == '0);
            Negative  <= res[MSB];
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (WIDTH=16, LANE=4); expectations follow ADDSUB_PIPE_SATURATE_EN.
module tb_addsub_pipe;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Carry;
    logic        Overflow;
    logic        Zero;
    logic        Negative;

    int compared   = 0;
    int mismatched = 0;

`ifdef ADDSUB_PIPE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    addsub_pipe #(.WIDTH(16), .LANE(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Mode      (Mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .Negative  (Negative)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [15:0] es, input logic ec,
                               input logic ev, input logic ez, input logic en);
        checkOutput({tag, ".S"}, {16'h0, S}, {16'h0, es});
        checkOutput({tag, ".Carry"}, {31'h0, Carry}, {31'h0, ec});
        checkOutput({tag, ".Overflow"}, {31'h0, Overflow}, {31'h0, ev});
        checkOutput({tag, ".Zero"}, {31'h0, Zero}, {31'h0, ez});
        checkOutput({tag, ".Negative"}, {31'h0, Negative}, {31'h0, en});
    endtask

    // Issue one operation into an empty pipeline (called at a negedge) and measure cycles to out_valid.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic m,
                                 output int lat);
        A        = a;
        B        = b;
        Mode     = m;
        in_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge Clk);
            @(negedge Clk);
            lat++;
        end
    endtask

    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        sm [8];
    logic [15:0] es [8];
    logic        ec [8];

    initial begin
        int lat;
        int wr;
        int rd;
        int seen;

        sa[0] = 16'h1234; sb[0] = 16'h1111; sm[0] = 1'b0; es[0] = 16'h2345; ec[0] = 1'b0;
        sa[1] = 16'h1234; sb[1] = 16'h0234; sm[1] = 1'b1; es[1] = 16'h1000; ec[1] = 1'b1;
        sa[2] = 16'h00FF; sb[2] = 16'h0001; sm[2] = 1'b0; es[2] = 16'h0100; ec[2] = 1'b0;
        sa[3] = 16'h0000; sb[3] = 16'h0001; sm[3] = 1'b1; es[3] = 16'hFFFF; ec[3] = 1'b0;
        sa[4] = 16'hFFFF; sb[4] = 16'h0001; sm[4] = 1'b0; es[4] = 16'h0000; ec[4] = 1'b1;
        sa[5] = 16'h7000; sb[5] = 16'h1000; sm[5] = 1'b1; es[5] = 16'h6000; ec[5] = 1'b1;
        sa[6] = 16'hABCD; sb[6] = 16'h1111; sm[6] = 1'b0; es[6] = 16'hBCDE; ec[6] = 1'b0;
        sa[7] = 16'h0F0F; sb[7] = 16'h0F0F; sm[7] = 1'b1; es[7] = 16'h0000; ec[7] = 1'b1;

        Rst_n     = 1'b0;
        in_valid  = 1'b1;
        A         = 16'hFFFF;
        B         = 16'hFFFF;
        Mode      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        Rst_n    = 1'b1;
        #1;
        checkOutput("reset.out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset.in_ready", {31'h0, in_ready}, 32'h1);
        checkResult("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] single operations");
        applyStimulus(16'h0001, 16'h0001, 1'b0, lat);
        checkOutput("add1.latency", lat, 4);
        checkResult("add1", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(16'hFFFF, 16'hBABA, 1'b0, lat);
        checkOutput("add2.latency", lat, 4);
        checkResult("add2", 16'hBAB9, 1'b1, 1'b0, 1'b0, 1'b1);

        applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
        checkOutput("ovfadd.latency", lat, 4);
        checkResult("ovfadd", SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT, SAT);

        applyStimulus(16'h4200, 16'h8800, 1'b1, lat);
        checkOutput("sub1.latency", lat, 4);
        checkResult("sub1", SAT ? 16'h7FFF : 16'hBA00, 1'b0, 1'b1, 1'b0, !SAT);

        applyStimulus(16'h6100, 16'h0900, 1'b1, lat);
        checkOutput("sub2.latency", lat, 4);
        checkResult("sub2", 16'h5800, 1'b1, 1'b0, 1'b0, 1'b0);

        // Streaming with a three-cycle downstream stall while the pipeline is full.
        $display("[TB] back-to-back stream with backpressure");
        @(negedge Clk);
        wr = 0;
        rd = 0;
        for (int cyc = 0; cyc < 60 && rd < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            if (wr < 8) begin
                A        = sa[wr];
                B        = sb[wr];
                Mode     = sm[wr];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 6 && cyc < 9) begin
                checkOutput("stall.in_ready", {31'h0, in_ready}, 32'h0);
                checkOutput("stall.out_valid", {31'h0, out_valid}, 32'h1);
                checkOutput("stall.S_frozen", {16'h0, S}, {16'h0, es[rd]});
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream%0d.S", rd), {16'h0, S}, {16'h0, es[rd]});
                checkOutput($sformatf("stream%0d.Carry", rd), {31'h0, Carry}, {31'h0, ec[rd]});
                checkOutput($sformatf("stream%0d.Overflow", rd), {31'h0, Overflow}, 32'h0);
                rd++;
            end
            if (in_valid && in_ready) begin
                wr++;
            end
            @(negedge Clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream.delivered", rd, 8);

        // Three operations in flight are discarded by reset.
        $display("[TB] reset with operations in flight");
        for (int i = 0; i < 3; i++) begin
            A        = sa[i];
            B        = sb[i];
            Mode     = sm[i];
            in_valid = 1'b1;
            @(posedge Clk);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        Rst_n    = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                seen++;
            end
            @(posedge Clk);
            @(negedge Clk);
        end
        checkOutput("rstflush.out_valid_seen", seen, 0);

        applyStimulus(16'h0003, 16'h0004, 1'b0, lat);
        checkOutput("fresh.latency", lat, 4);
        checkResult("fresh", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
